// File: rtl/araucaria_pkg.sv
// Shared arbiter types and constants: FSM state encodings, default RAM geometry, clog2 helper.
package araucaria_pkg;

  typedef enum logic [0:0] {
    ARB_STATE_ARB    = 1'b0,
    ARB_STATE_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned ARAU_DATA_WIDTH = 8;
  localparam int unsigned ARAU_ADDR_WIDTH = 10;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester bus plus RAM-side port bundle for ram_port_arbiter; slave = arbiter view.
interface ram_port_arbiter_if
  import araucaria_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = ARAU_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ARAU_ADDR_WIDTH
);
  logic [NREQ-1:0]            req;
  logic [NREQ-1:0]            we;
  logic [NREQ*ADDR_WIDTH-1:0] addr;
  logic [NREQ*DATA_WIDTH-1:0] data;
  logic [NREQ-1:0]            lock;
  logic [NREQ-1:0]            gnt_c;
  logic [NREQ-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]      rd_data_c;
  logic                       ram_we_c;
  logic [ADDR_WIDTH-1:0]      ram_rd_addr_c;
  logic [ADDR_WIDTH-1:0]      ram_wr_addr_c;
  logic [DATA_WIDTH-1:0]      ram_data_c;
  logic [DATA_WIDTH-1:0]      ram_q;

  modport slave (
    input  req, we, addr, data, lock, ram_q,
    output gnt_c, rd_valid, rd_data_c, ram_we_c, ram_rd_addr_c, ram_wr_addr_c, ram_data_c
  );

  modport master (
    output req, we, addr, data, lock, ram_q,
    input  gnt_c, rd_valid, rd_data_c, ram_we_c, ram_rd_addr_c, ram_wr_addr_c, ram_data_c
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Rotating priority encoder: first set request scanning upward from ptr, wrapping at NREQ-1.
module rr_pick
  import araucaria_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  // Walk from farthest to nearest so the nearest hit to ptr is the last one written.
  always_comb begin
    int j;
    onehot_c = '0;
    idx_c    = '0;
    any_c    = 1'b0;
    j        = 0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= int'(NREQ)) j = j - int'(NREQ);
      if (req[j]) begin
        onehot_c    = '0;
        onehot_c[j] = 1'b1;
        idx_c       = IDW'(j);
        any_c       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-read-port RAM among NREQ requesters.
// Optional burst locking is enabled by defining RAM_ARB_LOCK_EN.
module ram_port_arbiter
  import araucaria_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = ARAU_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ARAU_ADDR_WIDTH,
  parameter int unsigned MAX_BURST  = 4
) (
  input logic               Clock,
  input logic               Reset,
  ram_port_arbiter_if.slave bus
);

  localparam int unsigned IDW = clog2(NREQ);
  localparam int unsigned CW  = clog2(MAX_BURST + 1);

  arb_state_e      state, next_state;
  logic [IDW-1:0]  ptr, next_ptr, sel;
  logic [NREQ-1:0] pick_onehot_c, gnt_c, rd_valid_q;
  logic [IDW-1:0]  pick_idx_c;
  logic            pick_any_c, granted;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr),
    .onehot_c(pick_onehot_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
    return (32'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
  endfunction

`ifdef RAM_ARB_LOCK_EN
  logic [IDW-1:0] owner, next_owner;
  logic [CW-1:0]  count, next_count;
  logic           owner_hold;

  assign owner_hold = (state == ARB_STATE_LOCKED) && bus.req[owner] && bus.lock[owner];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      owner <= '0;
      count <= '0;
    end else begin
      owner <= next_owner;
      count <= next_count;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.lock, CW'(MAX_BURST)};
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ARB_STATE_ARB;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  // While locked, ptr already holds owner+1, so a release scan needs no separate start point.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    gnt_c      = '0;
    sel        = pick_idx_c;
    granted    = 1'b0;
`ifdef RAM_ARB_LOCK_EN
    next_owner = owner;
    next_count = count;
`endif
    if (!Reset) begin
`ifdef RAM_ARB_LOCK_EN
      if (owner_hold) begin
        gnt_c[owner] = 1'b1;
        sel          = owner;
        granted      = 1'b1;
        next_count   = count + CW'(1);
        if (32'(count) + 1 >= MAX_BURST) next_state = ARB_STATE_ARB;
      end else
`endif
      if (pick_any_c) begin
        gnt_c      = pick_onehot_c;
        granted    = 1'b1;
        next_ptr   = next_idx(pick_idx_c);
        next_state = ARB_STATE_ARB;
`ifdef RAM_ARB_LOCK_EN
        if (bus.lock[pick_idx_c]) begin
          next_state = ARB_STATE_LOCKED;
          next_owner = pick_idx_c;
          next_count = CW'(1);
        end
`endif
      end else begin
        next_state = ARB_STATE_ARB;
      end
    end
  end

  assign bus.gnt_c         = gnt_c;
  assign bus.ram_we_c      = granted & bus.we[sel];
  assign bus.ram_rd_addr_c = granted ? bus.addr[ADDR_WIDTH*32'(sel) +: ADDR_WIDTH] : '0;
  assign bus.ram_wr_addr_c = bus.ram_rd_addr_c;
  assign bus.ram_data_c    = granted ? bus.data[DATA_WIDTH*32'(sel) +: DATA_WIDTH] : '0;
  assign bus.rd_data_c     = bus.ram_q;

  // Read valid tracks the RAM's one-cycle registered read latency.
  always_ff @(posedge Clock) begin
    if (Reset) rd_valid_q <= '0;
    else       rd_valid_q <= bus.ram_we_c ? '0 : gnt_c;
  end

  // A read in flight when reset arrives is dropped rather than reported.
  assign bus.rd_valid = rd_valid_q & ~{NREQ{Reset}};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small registered-read RAM model.
module tb_ram_port_arbiter;
  import araucaria_pkg::*;

  localparam logic [39:0] ADDR_DEF = {10'h013, 10'h012, 10'h011, 10'h010};

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 Clock = ~Clock;

  ram_port_arbiter_if #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(10)) bus ();

  ram_port_arbiter #(.NREQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .MAX_BURST(4)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // RAM model: contents default to addr^0x3C, one-cycle registered read, same-cycle forwarding.
  logic [7:0] mem [0:1023];
  always @(posedge Clock) begin
    if (Reset) begin
      for (int a = 0; a < 1024; a++) mem[a] <= 8'(a) ^ 8'h3C;
    end else if (bus.ram_we_c) begin
      mem[bus.ram_wr_addr_c] <= bus.ram_data_c;
    end
    bus.ram_q <= (bus.ram_we_c && bus.ram_rd_addr_c == bus.ram_wr_addr_c) ?
                 bus.ram_data_c : mem[bus.ram_rd_addr_c];
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] w = 4'b0000,
                       input logic [3:0] l = 4'b0000, input logic rst = 1'b0,
                       input logic [39:0] a = ADDR_DEF, input logic [31:0] d = 32'h0);
    @(negedge Clock);
    Reset    = rst;
    bus.req  = r;
    bus.we   = w;
    bus.lock = l;
    bus.addr = a;
    bus.data = d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic exp_cyc(input string tag, input logic [3:0] g, input logic [3:0] rv,
                         input logic [7:0] rd = 8'h00);
    chk({tag, " gnt"}, 32'(bus.gnt_c), 32'(g));
    chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(rv));
    if (rv != 4'b0000) chk({tag, " rd_data"}, 32'(bus.rd_data_c), 32'(rd));
  endtask

  initial begin
    bus.req  = 4'hF;
    bus.we   = 4'b0001;
    bus.lock = 4'h0;
    bus.addr = ADDR_DEF;
    bus.data = 32'h0;

    // Reset held with all requesting (req0 asking to write)
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 4'b0001, 4'b0000, 1'b1);
      exp_cyc("reset", 4'b0000, 4'b0000);
      chk("reset ram_we", 32'(bus.ram_we_c), 32'd0);
      chk("reset ram_addr", 32'(bus.ram_rd_addr_c), 32'd0);
    end

    // Continuous reads: 0,1,2,3,0 with valid one cycle behind
    drive(4'hF);
    exp_cyc("rr0", 4'b0001, 4'b0000);
    chk("rr0 addr", 32'(bus.ram_rd_addr_c), 32'h010);
    chk("rr0 ram_we", 32'(bus.ram_we_c), 32'd0);
    drive(4'hF); exp_cyc("rr1", 4'b0010, 4'b0001, 8'h2C);
    chk("rr1 addr", 32'(bus.ram_rd_addr_c), 32'h011);
    drive(4'hF); exp_cyc("rr2", 4'b0100, 4'b0010, 8'h2D);
    drive(4'hF); exp_cyc("rr3", 4'b1000, 4'b0100, 8'h2E);
    drive(4'hF); exp_cyc("rr4", 4'b0001, 4'b1000, 8'h2F);
    drive(4'h0); exp_cyc("rr idle", 4'b0000, 4'b0001, 8'h2C);

    // Write by req1 then read of the same address by req2
    drive(4'b0010, 4'b0010, 4'b0000, 1'b0, {10'h013, 10'h012, 10'h005, 10'h010}, 32'h0000_A500);
    exp_cyc("raw wr", 4'b0010, 4'b0000);
    chk("raw wr ram_we", 32'(bus.ram_we_c), 32'd1);
    chk("raw wr addr", 32'(bus.ram_wr_addr_c), 32'h005);
    chk("raw wr data", 32'(bus.ram_data_c), 32'hA5);
    drive(4'b0100, 4'b0000, 4'b0000, 1'b0, {10'h013, 10'h005, 10'h011, 10'h010});
    exp_cyc("raw rd", 4'b0100, 4'b0000);
    chk("raw rd ram_we", 32'(bus.ram_we_c), 32'd0);
    chk("raw rd addr", 32'(bus.ram_rd_addr_c), 32'h005);
    drive(4'h0); exp_cyc("raw ret", 4'b0000, 4'b0100, 8'hA5);

    // Pointer wrap and hold (ptr=3 -> req1 wins, ptr=2)
    drive(4'b0010); exp_cyc("wrap a", 4'b0010, 4'b0000);
    drive(4'b0011); exp_cyc("wrap b", 4'b0001, 4'b0010, 8'h2D);
    drive(4'b0010); exp_cyc("wrap c", 4'b0010, 4'b0001, 8'h2C);
    drive(4'b0000); exp_cyc("hold a", 4'b0000, 4'b0010, 8'h2D);
    drive(4'b0000); exp_cyc("hold b", 4'b0000, 4'b0000);
    drive(4'hF);    exp_cyc("hold ptr", 4'b0100, 4'b0000);
    drive(4'b0011); exp_cyc("wrap d", 4'b0001, 4'b0100, 8'h2E);

    // Reset the cycle after a granted read drops the return
    drive(4'b0001); exp_cyc("rst rd", 4'b0001, 4'b0001, 8'h2C);
    drive(4'hF, 4'b0000, 4'b0000, 1'b1); exp_cyc("rst drop", 4'b0000, 4'b0000);
    drive(4'hF); exp_cyc("rst ptr0", 4'b0001, 4'b0000);
    drive(4'h0); exp_cyc("rst ret", 4'b0000, 4'b0001, 8'h2C);

`ifdef RAM_ARB_LOCK_EN
    // Burst lock: forced release after 4, then early release on lock drop
    drive(4'b0010); exp_cyc("lk pre", 4'b0010, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0011, 4'b0000, 4'b0001);
      exp_cyc("lk burst", 4'b0001, (i == 0) ? 4'b0010 : 4'b0001, (i == 0) ? 8'h2D : 8'h2C);
    end
    drive(4'b0011, 4'b0000, 4'b0001); exp_cyc("lk release", 4'b0010, 4'b0001, 8'h2C);
    drive(4'b0011, 4'b0000, 4'b0001); exp_cyc("lk2 a", 4'b0001, 4'b0010, 8'h2D);
    drive(4'b0011, 4'b0000, 4'b0001); exp_cyc("lk2 b", 4'b0001, 4'b0001, 8'h2C);
    drive(4'b0011, 4'b0000, 4'b0000); exp_cyc("lk2 drop", 4'b0010, 4'b0001, 8'h2C);
`else
    // Lock requests are ignored: plain alternation
    drive(4'b0010); exp_cyc("nolk pre", 4'b0010, 4'b0000);
    drive(4'b0011, 4'b0000, 4'b0011); exp_cyc("nolk a", 4'b0001, 4'b0010, 8'h2D);
    drive(4'b0011, 4'b0000, 4'b0011); exp_cyc("nolk b", 4'b0010, 4'b0001, 8'h2C);
    drive(4'b0011, 4'b0000, 4'b0011); exp_cyc("nolk c", 4'b0001, 4'b0010, 8'h2D);
    drive(4'b0011, 4'b0000, 4'b0011); exp_cyc("nolk d", 4'b0010, 4'b0001, 8'h2C);
`endif
    drive(4'h0); exp_cyc("end idle", 4'b0000, 4'b0010, 8'h2D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
